// File: rtl/arith_issue_queue.sv
// arith_issue_queue: in-order-age ALU reservation station with two wakeup ports.
// Optional feature macro ARITH_IQ_BYPASS_EN: wakeups count as ready for same-cycle select.

module arith_iq_opnd_wake #(
    parameter int TAG_W = 5
) (
    input  logic             rdy,
    input  logic [TAG_W-1:0] tag,
    input  logic [7:0]       val,
    input  logic             wk0_valid,
    input  logic [TAG_W-1:0] wk0_tag,
    input  logic [7:0]       wk0_val,
    input  logic             wk1_valid,
    input  logic [TAG_W-1:0] wk1_tag,
    input  logic [7:0]       wk1_val,
    output logic             woke_rdy,
    output logic [7:0]       woke_val
);
    logic hit0, hit1;

    assign hit0     = ~rdy & wk0_valid & (wk0_tag == tag);
    assign hit1     = ~rdy & wk1_valid & (wk1_tag == tag);
    assign woke_rdy = rdy | hit0 | hit1;
    // wk0 wins when both ports broadcast the same tag
    assign woke_val = hit0 ? wk0_val : (hit1 ? wk1_val : val);
endmodule

module arith_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [3:0]                   disp_opcode,
    input  logic [TAG_W-1:0]             disp_rob,
    input  logic [TAG_W-1:0]             disp_dest,
    input  logic [TAG_W-1:0]             disp_flag_dest,
    input  logic [TAG_W-1:0]             disp_a_tag,
    input  logic [TAG_W-1:0]             disp_b_tag,
    input  logic [TAG_W-1:0]             disp_f_tag,
    input  logic                         disp_a_rdy,
    input  logic                         disp_b_rdy,
    input  logic                         disp_f_rdy,
    input  logic [7:0]                   disp_a_val,
    input  logic [7:0]                   disp_b_val,
    input  logic [7:0]                   disp_f_val,
    input  logic                         wk0_valid,
    input  logic [TAG_W-1:0]             wk0_tag,
    input  logic [7:0]                   wk0_val,
    input  logic                         wk1_valid,
    input  logic [TAG_W-1:0]             wk1_tag,
    input  logic [7:0]                   wk1_val,
    output logic                         instr_valid,
    output logic [3:0]                   opcode,
    output logic [TAG_W-1:0]             ROB_entry,
    output logic [TAG_W-1:0]             dest_reg,
    output logic [TAG_W-1:0]             flag_reg,
    output logic [7:0]                   op_a_val,
    output logic [7:0]                   op_b_val,
    output logic [7:0]                   flags_val,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [7:0]       val;
    } opnd_t;

    typedef struct packed {
        logic             valid;
        logic [3:0]       opcode;
        logic [TAG_W-1:0] rob;
        logic [TAG_W-1:0] dest;
        logic [TAG_W-1:0] flag_dest;
        opnd_t            a;
        opnd_t            b;
        opnd_t            f;
    } entry_t;

    entry_t q    [DEPTH];
    entry_t upd  [DEPTH];   // stored entries with this cycle's wakeups applied
    entry_t shft [DEPTH];   // upd shifted down by one slot
    entry_t nxt  [DEPTH];
    entry_t dent;
    entry_t iss;

    logic [DEPTH-1:0] elig;
    logic             seen, issue, accept;
    logic [CW-1:0]    cnt_after;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic       ar, br, fr;
        logic [7:0] av, bv, fv;
        entry_t     u;

        arith_iq_opnd_wake #(.TAG_W(TAG_W)) u_a (
            .rdy(q[i].a.rdy), .tag(q[i].a.tag), .val(q[i].a.val),
            .wk0_valid(wk0_valid), .wk0_tag(wk0_tag), .wk0_val(wk0_val),
            .wk1_valid(wk1_valid), .wk1_tag(wk1_tag), .wk1_val(wk1_val),
            .woke_rdy(ar), .woke_val(av));
        arith_iq_opnd_wake #(.TAG_W(TAG_W)) u_b (
            .rdy(q[i].b.rdy), .tag(q[i].b.tag), .val(q[i].b.val),
            .wk0_valid(wk0_valid), .wk0_tag(wk0_tag), .wk0_val(wk0_val),
            .wk1_valid(wk1_valid), .wk1_tag(wk1_tag), .wk1_val(wk1_val),
            .woke_rdy(br), .woke_val(bv));
        arith_iq_opnd_wake #(.TAG_W(TAG_W)) u_f (
            .rdy(q[i].f.rdy), .tag(q[i].f.tag), .val(q[i].f.val),
            .wk0_valid(wk0_valid), .wk0_tag(wk0_tag), .wk0_val(wk0_val),
            .wk1_valid(wk1_valid), .wk1_tag(wk1_tag), .wk1_val(wk1_val),
            .woke_rdy(fr), .woke_val(fv));

        always_comb begin
            u       = q[i];
            u.a.rdy = ar;
            u.a.val = av;
            u.b.rdy = br;
            u.b.val = bv;
            u.f.rdy = fr;
            u.f.val = fv;
        end
        assign upd[i] = u;

`ifdef ARITH_IQ_BYPASS_EN
        assign elig[i] = q[i].valid & ar & br & fr;
`else
        assign elig[i] = q[i].valid & q[i].a.rdy & q[i].b.rdy & q[i].f.rdy;
`endif

        if (i < DEPTH-1) begin : g_sh
            assign shft[i] = upd[i+1];
        end else begin : g_top
            assign shft[i] = '0;
        end
    end

    logic       dar, dbr, dfr;
    logic [7:0] dav, dbv, dfv;

    arith_iq_opnd_wake #(.TAG_W(TAG_W)) u_da (
        .rdy(disp_a_rdy), .tag(disp_a_tag), .val(disp_a_val),
        .wk0_valid(wk0_valid), .wk0_tag(wk0_tag), .wk0_val(wk0_val),
        .wk1_valid(wk1_valid), .wk1_tag(wk1_tag), .wk1_val(wk1_val),
        .woke_rdy(dar), .woke_val(dav));
    arith_iq_opnd_wake #(.TAG_W(TAG_W)) u_db (
        .rdy(disp_b_rdy), .tag(disp_b_tag), .val(disp_b_val),
        .wk0_valid(wk0_valid), .wk0_tag(wk0_tag), .wk0_val(wk0_val),
        .wk1_valid(wk1_valid), .wk1_tag(wk1_tag), .wk1_val(wk1_val),
        .woke_rdy(dbr), .woke_val(dbv));
    arith_iq_opnd_wake #(.TAG_W(TAG_W)) u_df (
        .rdy(disp_f_rdy), .tag(disp_f_tag), .val(disp_f_val),
        .wk0_valid(wk0_valid), .wk0_tag(wk0_tag), .wk0_val(wk0_val),
        .wk1_valid(wk1_valid), .wk1_tag(wk1_tag), .wk1_val(wk1_val),
        .woke_rdy(dfr), .woke_val(dfv));

    always_comb begin
        dent           = '0;
        dent.valid     = 1'b1;
        dent.opcode    = disp_opcode;
        dent.rob       = disp_rob;
        dent.dest      = disp_dest;
        dent.flag_dest = disp_flag_dest;
        dent.a         = '{rdy: dar, tag: disp_a_tag, val: dav};
        dent.b         = '{rdy: dbr, tag: disp_b_tag, val: dbv};
        dent.f         = '{rdy: dfr, tag: disp_f_tag, val: dfv};
    end

    assign disp_ready = (count < CW'(DEPTH));

    // seen marks the selected slot and everything above it; those slots take
    // their upper neighbour, which both removes the issued entry and compacts
    always_comb begin
        seen = 1'b0;
        iss  = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (elig[j] && !seen)
                iss = upd[j];
            seen   = seen | elig[j];
            nxt[j] = (seen && !flush) ? shft[j] : upd[j];
            if (flush)
                nxt[j].valid = 1'b0;
        end
        issue     = seen & ~flush;
        accept    = disp_valid & disp_ready & ~flush;
        cnt_after = count - CW'(issue);
        for (int j = 0; j < DEPTH; j++) begin
            if (accept && cnt_after == CW'(j))
                nxt[j] = dent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++)
                q[j] <= '0;
            count       <= '0;
            instr_valid <= 1'b0;
            opcode      <= '0;
            ROB_entry   <= '0;
            dest_reg    <= '0;
            flag_reg    <= '0;
            op_a_val    <= '0;
            op_b_val    <= '0;
            flags_val   <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++)
                q[j] <= nxt[j];
            count       <= flush ? '0 : cnt_after + CW'(accept);
            instr_valid <= issue;
            if (issue) begin
                opcode    <= iss.opcode;
                ROB_entry <= iss.rob;
                dest_reg  <= iss.dest;
                flag_reg  <= iss.flag_dest;
                op_a_val  <= iss.a.val;
                op_b_val  <= iss.b.val;
                flags_val <= iss.f.val;
            end
        end
    end
endmodule

// File: tb/tb_arith_issue_queue.sv
// Directed self-checking bench for arith_issue_queue (DEPTH=4, TAG_W=5).
// Wakeup latency expectations follow ARITH_IQ_BYPASS_EN when it is defined.

module tb_arith_issue_queue;
    logic       clk, rst, flush;
    logic       disp_valid, disp_ready;
    logic [3:0] disp_opcode;
    logic [4:0] disp_rob, disp_dest, disp_flag_dest;
    logic [4:0] disp_a_tag, disp_b_tag, disp_f_tag;
    logic       disp_a_rdy, disp_b_rdy, disp_f_rdy;
    logic [7:0] disp_a_val, disp_b_val, disp_f_val;
    logic       wk0_valid, wk1_valid;
    logic [4:0] wk0_tag, wk1_tag;
    logic [7:0] wk0_val, wk1_val;
    logic       instr_valid;
    logic [3:0] opcode;
    logic [4:0] ROB_entry, dest_reg, flag_reg;
    logic [7:0] op_a_val, op_b_val, flags_val;
    logic [2:0] count;

    int checks, errors;

    arith_issue_queue #(.DEPTH(4), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_rob(disp_rob), .disp_dest(disp_dest),
        .disp_flag_dest(disp_flag_dest),
        .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag), .disp_f_tag(disp_f_tag),
        .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy), .disp_f_rdy(disp_f_rdy),
        .disp_a_val(disp_a_val), .disp_b_val(disp_b_val), .disp_f_val(disp_f_val),
        .wk0_valid(wk0_valid), .wk0_tag(wk0_tag), .wk0_val(wk0_val),
        .wk1_valid(wk1_valid), .wk1_tag(wk1_tag), .wk1_val(wk1_val),
        .instr_valid(instr_valid), .opcode(opcode), .ROB_entry(ROB_entry),
        .dest_reg(dest_reg), .flag_reg(flag_reg),
        .op_a_val(op_a_val), .op_b_val(op_b_val), .flags_val(flags_val),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        disp_valid = 1'b0;
        wk0_valid  = 1'b0;
        wk1_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic put(input logic [3:0] op, input logic [4:0] rob, input logic [4:0] dst,
                       input logic [4:0] fd,
                       input logic ar, input logic [4:0] at, input logic [7:0] av,
                       input logic br, input logic [4:0] bt, input logic [7:0] bv,
                       input logic fr, input logic [4:0] ft, input logic [7:0] fv);
        disp_valid = 1'b1;  disp_opcode = op;  disp_rob = rob;
        disp_dest = dst;    disp_flag_dest = fd;
        disp_a_rdy = ar;    disp_a_tag = at;   disp_a_val = av;
        disp_b_rdy = br;    disp_b_tag = bt;   disp_b_val = bv;
        disp_f_rdy = fr;    disp_f_tag = ft;   disp_f_val = fv;
    endtask

    task automatic test_reset_state();
        step(); step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", count); end
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", disp_ready); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_iv: got %b exp 0", instr_valid); end
        checks++; if (ROB_entry !== 5'd0) begin errors++; $display("FAIL rst_rob: got %0h exp 0", ROB_entry); end
        #2 rst = 1'b0;
    endtask

    task automatic test_basic_issue();
        put(4'h0, 5'd1, 5'd2, 5'hF, 1'b1, 5'd0, 8'h01, 1'b1, 5'd0, 8'h02, 1'b1, 5'd0, 8'hFF);
        step(); clr_in();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count1: got %0d exp 1", count); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_iv_early: got %b exp 0", instr_valid); end
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_iv: got %b exp 1", instr_valid); end
        checks++; if (opcode !== 4'h0) begin errors++; $display("FAIL basic_op: got %0h exp 0", opcode); end
        checks++; if (ROB_entry !== 5'd1) begin errors++; $display("FAIL basic_rob: got %0h exp 1", ROB_entry); end
        checks++; if (dest_reg !== 5'd2) begin errors++; $display("FAIL basic_dest: got %0h exp 2", dest_reg); end
        checks++; if (flag_reg !== 5'hF) begin errors++; $display("FAIL basic_flag: got %0h exp f", flag_reg); end
        checks++; if (op_a_val !== 8'h01) begin errors++; $display("FAIL basic_a: got %0h exp 01", op_a_val); end
        checks++; if (op_b_val !== 8'h02) begin errors++; $display("FAIL basic_b: got %0h exp 02", op_b_val); end
        checks++; if (flags_val !== 8'hFF) begin errors++; $display("FAIL basic_f: got %0h exp ff", flags_val); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count0: got %0d exp 0", count); end
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b exp 0", instr_valid); end
        checks++; if (op_a_val !== 8'h01) begin errors++; $display("FAIL basic_hold: got %0h exp 01", op_a_val); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            put(4'h5, 5'(8+i), 5'(16+i), 5'(24+i), 1'b0, 5'(20+i), 8'h00,
                1'b1, 5'd0, 8'hAA, 1'b1, 5'd0, 8'hBB);
            step();
        end
        clr_in();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count3: got %0d exp 3", count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d exp 0", count); end
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b exp 1", disp_ready); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_iv: got %b exp 0", instr_valid); end
        checks++; if (ROB_entry !== 5'd0 || dest_reg !== 5'd0 || flag_reg !== 5'd0)
            begin errors++; $display("FAIL mid_tags: got %0h/%0h/%0h exp 0/0/0", ROB_entry, dest_reg, flag_reg); end
        checks++; if (op_a_val !== 8'd0 || op_b_val !== 8'd0 || flags_val !== 8'd0)
            begin errors++; $display("FAIL mid_vals: got %0h/%0h/%0h exp 0/0/0", op_a_val, op_b_val, flags_val); end
        #2 rst = 1'b0;
        step();
    endtask

    task automatic test_wakeup();
        put(4'h3, 5'd5, 5'd6, 5'd7, 1'b0, 5'd7, 8'hEE, 1'b1, 5'd0, 8'h02, 1'b1, 5'd0, 8'h00);
        step(); clr_in();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL wk_count: got %0d exp 1", count); end
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wk_wait: got %b exp 0", instr_valid); end
        wk1_valid = 1'b1; wk1_tag = 5'd7; wk1_val = 8'h33;
        step(); clr_in();
`ifndef ARITH_IQ_BYPASS_EN
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wk_early: got %b exp 0", instr_valid); end
        step();
`endif
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wk_iv: got %b exp 1", instr_valid); end
        checks++; if (op_a_val !== 8'h33) begin errors++; $display("FAIL wk_a: got %0h exp 33", op_a_val); end
        checks++; if (op_b_val !== 8'h02) begin errors++; $display("FAIL wk_b: got %0h exp 02", op_b_val); end
        checks++; if (ROB_entry !== 5'd5) begin errors++; $display("FAIL wk_rob: got %0h exp 5", ROB_entry); end
        step();
        checks++; if (instr_valid !== 1'b0 || count !== 3'd0)
            begin errors++; $display("FAIL wk_done: got iv=%b cnt=%0d exp iv=0 cnt=0", instr_valid, count); end
    endtask

    task automatic test_dispatch_wakeup();
        put(4'h2, 5'd9, 5'd10, 5'd11, 1'b0, 5'd3, 8'h00, 1'b0, 5'd3, 8'h00, 1'b1, 5'd0, 8'h5A);
        wk0_valid = 1'b1; wk0_tag = 5'd3; wk0_val = 8'h44;
        wk1_valid = 1'b1; wk1_tag = 5'd3; wk1_val = 8'h55;
        step(); clr_in();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL dw_count: got %0d exp 1", count); end
        step();
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL dw_iv: got %b exp 1", instr_valid); end
        checks++; if (op_a_val !== 8'h44 || op_b_val !== 8'h44)
            begin errors++; $display("FAIL dw_prio: got a=%0h b=%0h exp 44/44", op_a_val, op_b_val); end
        checks++; if (flags_val !== 8'h5A) begin errors++; $display("FAIL dw_f: got %0h exp 5a", flags_val); end
    endtask

    task automatic test_age_order();
        logic [4:0] got [4];
        int n;
        for (int i = 0; i < 4; i++) begin
            put(4'h1, 5'(1+i), 5'(1+i), 5'(1+i), 1'b0, 5'(10+i), 8'h00,
                1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00);
            step();
            checks++; if (disp_ready !== logic'(i < 3))
                begin errors++; $display("FAIL age_ready%0d: got %b exp %b", i, disp_ready, i < 3); end
        end
        clr_in();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL age_full: got %0d exp 4", count); end
        n = 0;
        for (int c = 0; c < 5; c++) begin
            wk0_valid = (c < 2); wk0_tag = (c == 0) ? 5'd13 : 5'd11; wk0_val = 8'hD0;
            step();
            if (instr_valid) begin if (n < 4) got[n] = ROB_entry; n++; end
        end
        clr_in();
        checks++; if (n != 2 || got[0] !== 5'd4 || got[1] !== 5'd2)
            begin errors++; $display("FAIL age_order1: got n=%0d %0d,%0d exp n=2 4,2", n, got[0], got[1]); end
        checks++; if (count !== 3'd2 || disp_ready !== 1'b1)
            begin errors++; $display("FAIL age_cnt2: got %0d/%b exp 2/1", count, disp_ready); end
        n = 0;
        for (int c = 0; c < 4; c++) begin
            wk0_valid = (c == 0); wk0_tag = 5'd10; wk0_val = 8'h10;
            wk1_valid = (c == 0); wk1_tag = 5'd12; wk1_val = 8'h12;
            step();
            if (instr_valid) begin if (n < 4) got[n] = ROB_entry; n++; end
        end
        clr_in();
        checks++; if (n != 2 || got[0] !== 5'd1 || got[1] !== 5'd3)
            begin errors++; $display("FAIL age_order2: got n=%0d %0d,%0d exp n=2 1,3", n, got[0], got[1]); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL age_empty: got %0d exp 0", count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 3; i++) begin
            put(4'h4, 5'(16+i), 5'd1, 5'd1, 1'b0, 5'(20+i), 8'h00,
                1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00);
            step();
        end
        put(4'h4, 5'd19, 5'd1, 5'd1, 1'b1, 5'd0, 8'h01, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00);
        step();
        checks++; if (count !== 3'd4 || disp_ready !== 1'b0)
            begin errors++; $display("FAIL full_4: got %0d/%b exp 4/0", count, disp_ready); end
        put(4'h4, 5'd20, 5'd1, 5'd1, 1'b0, 5'd23, 8'h00, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00);
        step();
        checks++; if (instr_valid !== 1'b1 || ROB_entry !== 5'd19)
            begin errors++; $display("FAIL full_issue: got %b/%0d exp 1/19", instr_valid, ROB_entry); end
        checks++; if (count !== 3'd3 || disp_ready !== 1'b1)
            begin errors++; $display("FAIL full_3: got %0d/%b exp 3/1", count, disp_ready); end
        step(); clr_in();
        checks++; if (count !== 3'd4 || disp_ready !== 1'b0 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL full_refill: got %0d/%b/%b exp 4/0/0", count, disp_ready, instr_valid); end
    endtask

    task automatic test_flush();
        logic any_iv;
        flush = 1'b1;
        step(); clr_in();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fl_clear: got %0d exp 0", count); end
        put(4'h7, 5'd11, 5'd1, 5'd1, 1'b0, 5'd24, 8'h00, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00);
        step();
        put(4'h7, 5'd12, 5'd1, 5'd1, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00);
        step();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL fl_count2: got %0d exp 2", count); end
        put(4'h7, 5'd13, 5'd1, 5'd1, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00);
        flush = 1'b1;
        step(); clr_in();
        checks++; if (count !== 3'd0 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL fl_edge: got %0d/%b exp 0/0", count, instr_valid); end
        any_iv = 1'b0;
        repeat (3) begin step(); any_iv = any_iv | instr_valid; end
        checks++; if (any_iv !== 1'b0 || count !== 3'd0)
            begin errors++; $display("FAIL fl_quiet: got iv=%b cnt=%0d exp 0/0", any_iv, count); end
    endtask

    task automatic test_back_to_back();
        put(4'h6, 5'd1, 5'd1, 5'd1, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00);
        step();
        checks++; if (count !== 3'd1 || instr_valid !== 1'b0)
            begin errors++; $display("FAIL b2b_first: got %0d/%b exp 1/0", count, instr_valid); end
        for (int i = 2; i <= 3; i++) begin
            put(4'h6, 5'(i), 5'd1, 5'd1, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00, 1'b1, 5'd0, 8'h00);
            step();
            checks++; if (instr_valid !== 1'b1 || ROB_entry !== 5'(i-1) || count !== 3'd1)
                begin errors++; $display("FAIL b2b_%0d: got %b/%0d/%0d exp 1/%0d/1", i, instr_valid, ROB_entry, count, i-1); end
        end
        clr_in();
        step();
        checks++; if (instr_valid !== 1'b1 || ROB_entry !== 5'd3 || count !== 3'd0)
            begin errors++; $display("FAIL b2b_last: got %b/%0d/%0d exp 1/3/0", instr_valid, ROB_entry, count); end
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", instr_valid); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        clr_in();
        put(4'h0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
        disp_valid = 1'b0;
        wk0_tag = 5'd0; wk0_val = 8'h00; wk1_tag = 5'd0; wk1_val = 8'h00;
        test_reset_state();
        test_basic_issue();
        test_reset_mid();
        test_wakeup();
        test_dispatch_wakeup();
        test_age_order();
        test_full();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
